debug_cmd_ctrl: RTL and testbench
=================================

DEBUG_CMD_CTRL -- requirements
Module: debug_cmd_ctrl

Interface
REQ-001 Parameter ARG_TIMEOUT, default 1_000_000, is the number of idle clk cycles after which a partial argument is discarded.
REQ-002 Parameter PC_W, default 32, is the width of the PC, breakpoint and program word.
REQ-003 clk  in  1  single system clock; all logic is on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 rx_data  in  8  byte from the UART receiver.
REQ-006 rx_valid  in  1  one-cycle pulse: rx_data is valid.
REQ-007 tx_data  out  8  byte to the UART transmitter.
REQ-008 tx_valid  out  1  tx_data is valid; held until tx_ready.
REQ-009 tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready.
REQ-010 cpu_pc  in  PC_W  current CPU PC (byte address).
REQ-011 instr_done  in  1  one-cycle pulse: the CPU retired an instruction.
REQ-012 cpu_pause  out  1  level: 1 freezes the CPU.
REQ-013 cpu_step  out  1  one-cycle pulse: execute one instruction while paused.
REQ-014 prog_we  out  1  one-cycle instruction-memory write strobe.
REQ-015 prog_addr  out  PC_W  word address for prog_we.
REQ-016 prog_wdata  out  PC_W  write data for prog_we.

Function
REQ-017 Opcodes: SIGNAL 0x01 and OK 0x02 are transmitted; PING 0x03, PAUSE 0x04, RESUME 0x05, NEXT 0x06 and PROGRAM 0x07 are received; any other opcode byte received in CMD is ignored.
REQ-018 Receive FSM states: CMD, ARG, STEP_WAIT.
- CMD: each rx_valid byte is decoded as an opcode.
- RESUME and PROGRAM: go to ARG with argument byte count 0.
REQ-019 ARG: collect 4 bytes little-endian; every byte is data, including values that match opcodes.
- After the 4th byte, execute the command in the following cycle and return to CMD.
REQ-020 ARG timeout: if ARG_TIMEOUT cycles pass with no rx_valid, discard the partial argument and return to CMD with no side effect.
- The timeout counter reloads on every byte.
REQ-021 PING: request an OK response (1 byte, 0x02).
REQ-022 PAUSE: set pause_reg and request a SIGNAL response.
- The SIGNAL response is 5 bytes: 0x01, then the cpu_pc value sampled at request time, LSB first.
- PAUSE while already paused resends SIGNAL.
REQ-023 RESUME+arg: bp = arg; clear pause_reg; disarm the breakpoint until the first instr_done; bp == 0 disables breakpoints.
REQ-024 Breakpoint hit: while running, armed, bp != 0 and cpu_pc == bp:
- cpu_pause is asserted combinationally in that same cycle;
- pause_reg is set on the next edge;
- one SIGNAL is requested.
REQ-025 NEXT while paused: pulse cpu_step for exactly 1 cycle, then enter STEP_WAIT.
- On instr_done, request SIGNAL and return to CMD.
- NEXT while running is ignored.
- Bytes received in STEP_WAIT are dropped.
REQ-026 PROGRAM+arg: one prog_we pulse with prog_wdata = arg and prog_addr = prog_ptr, then prog_ptr increments.
- prog_ptr wraps modulo 2^PC_W.
- prog_ptr clears on RESUME.
- PROGRAM is accepted running or paused.
REQ-027 TX arbiter: one pending flag per response type; a request while the same flag is set is merged.
- When idle, OK has priority over SIGNAL.
- A frame is never interrupted; requests raised mid-frame are latched and sent afterwards.
REQ-028 tx_data and tx_valid stay stable while tx_valid && !tx_ready.
REQ-029 Simultaneous breakpoint hit and PAUSE decode: the result is one pause and one SIGNAL frame.

Reset
REQ-030 rst asserted clears the following to 0 immediately, regardless of clock:
- the FSM returns to CMD;
- pause_reg, bp, prog_ptr, pending flags, the TX frame, the timeout counter, cpu_step, prog_we and tx_valid.
REQ-031 Reset mid-frame or mid-ARG abandons that frame or argument; after release the CPU runs (cpu_pause = 0).

Structure
REQ-032 Opcode constants and FSM state encodings live in the shared debug package used by the UART and top-level blocks.
REQ-033 The TX arbiter/serializer is the single sub-module debug_tx_sched, containing the pending flags, the byte index and the PC snapshot.

Verification
REQ-034 Bytes 0x03 -> exactly one tx byte 0x02; cpu_pause stays 0.
REQ-035 Bytes 0x04 with cpu_pc = 0x40 -> cpu_pause = 1; tx sequence 01 40 00 00 00.
REQ-036 Bytes 05 04 00 00 00, then cpu_pc advances 0, 4 -> cpu_pause = 1 in the cycle cpu_pc = 4; tx 01 04 00 00 00.
REQ-037 While paused, bytes 06 06:
- one cpu_step pulse per NEXT;
- one SIGNAL frame per instr_done;
- the second NEXT (sent before the first instr_done) is dropped.
REQ-038 Bytes 07 01 01 01 01 twice -> prog_we at addr 0 then 1, both with data 0x01010101; bytes 07 07 07 07 07 -> a single write of 0x07070707.
REQ-039 Bytes 05 12, then ARG_TIMEOUT idle cycles, then 03 -> no resume, no bp change, tx 0x02; tx_ready held low for 3 cycles mid-frame -> data held, no byte lost.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared debug-link definitions: opcodes, receive FSM states
// and the SIGNAL frame byte helper.
package debug_pkg;

  localparam logic [7:0] OP_SIGNAL  = 8'h01;
  localparam logic [7:0] OP_OK      = 8'h02;
  localparam logic [7:0] OP_PING    = 8'h03;
  localparam logic [7:0] OP_PAUSE   = 8'h04;
  localparam logic [7:0] OP_RESUME  = 8'h05;
  localparam logic [7:0] OP_NEXT    = 8'h06;
  localparam logic [7:0] OP_PROGRAM = 8'h07;

  localparam int SIG_PC_BYTES = 4;

  typedef enum logic [1:0] {
    ST_CMD,
    ST_ARG,
    ST_STEP_WAIT
  } rx_state_t;

  // Byte k of a PC snapshot, LSB first
  function automatic logic [7:0] pc_byte(
    input logic [31:0] pc,
    input logic [1:0]  k
  );
    return pc[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/debug_tx_sched.sv
// Response arbiter and serializer: pending flags, PC snapshot
// and byte index for OK and SIGNAL frames.
module debug_tx_sched
  import debug_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ok_req,
  input  logic        sig_req,
  input  logic [31:0] sig_pc,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid
);

  logic        ok_pend;
  logic        sig_pend;
  logic        is_sig;
  logic [2:0]  idx;
  logic [31:0] snap_pc;
  logic [31:0] frame_pc;
  logic        start_ok;
  logic        start_sig;

  // A new frame only starts when the line is idle; OK wins
  always_comb begin
    start_ok  = !tx_valid && ok_pend;
    start_sig = !tx_valid && !ok_pend && sig_pend;
  end

  // Latch requests, start frames, advance bytes on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_pend  <= 1'b0;
      sig_pend <= 1'b0;
      is_sig   <= 1'b0;
      idx      <= 3'd0;
      snap_pc  <= 32'd0;
      frame_pc <= 32'd0;
      tx_data  <= 8'd0;
      tx_valid <= 1'b0;
    end else begin
      if (start_ok) begin
        tx_valid <= 1'b1;
        tx_data  <= OP_OK;
        is_sig   <= 1'b0;
      end else if (start_sig) begin
        tx_valid <= 1'b1;
        tx_data  <= OP_SIGNAL;
        is_sig   <= 1'b1;
        idx      <= 3'd0;
        frame_pc <= snap_pc;
      end else if (tx_valid && tx_ready) begin
        if (is_sig && idx != 3'(SIG_PC_BYTES)) begin
          tx_data <= pc_byte(frame_pc, idx[1:0]);
          idx     <= idx + 3'd1;
        end else begin
          tx_valid <= 1'b0;
        end
      end
      if (start_ok) ok_pend <= 1'b0;
      if (ok_req)   ok_pend <= 1'b1;
      if (start_sig) sig_pend <= 1'b0;
      if (sig_req && (!sig_pend || start_sig)) begin
        sig_pend <= 1'b1;
        snap_pc  <= sig_pc;
      end
    end
  end

endmodule

// File: rtl/debug_cmd_ctrl.sv
// UART debug command controller: decodes host commands,
// drives pause/step/program strobes, requests responses.
module debug_cmd_ctrl
  import debug_pkg::*;
#(
  parameter int ARG_TIMEOUT = 1_000_000,
  parameter int PC_W        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  input  logic [PC_W-1:0] cpu_pc,
  input  logic            instr_done,
  output logic            cpu_pause,
  output logic            cpu_step,
  output logic            prog_we,
  output logic [PC_W-1:0] prog_addr,
  output logic [PC_W-1:0] prog_wdata
);

  localparam int TW = $clog2(ARG_TIMEOUT + 1);

  rx_state_t       state, state_n;
  logic            pause_reg;
  logic            armed;
  logic            exec_pend;
  logic            exec_prog;
  logic [1:0]      cnt;
  logic [31:0]     arg;
  logic [TW-1:0]   idle;
  logic [PC_W-1:0] bp;
  logic [PC_W-1:0] prog_ptr;
  logic            bp_hit;
  logic            ok_req;
  logic            dec_sig;
  logic            pause_set;
  logic            step_req;
  logic            arg_start;
  logic            arg_take;
  logic            arg_last;
  logic            prog_sel;

  assign bp_hit     = !pause_reg && armed && (bp != '0)
                      && (cpu_pc == bp);
  assign cpu_pause  = pause_reg | bp_hit;
  assign prog_we    = exec_pend & exec_prog;
  assign prog_addr  = prog_ptr;
  assign prog_wdata = PC_W'(arg);

  // Receive FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_CMD;
    else     state <= state_n;
  end

  // Opcode decode, argument collection, timeout, step wait
  always_comb begin
    state_n   = state;
    ok_req    = 1'b0;
    dec_sig   = 1'b0;
    pause_set = 1'b0;
    step_req  = 1'b0;
    arg_start = 1'b0;
    arg_take  = 1'b0;
    arg_last  = 1'b0;
    prog_sel  = 1'b0;
    unique case (state)
      ST_CMD: if (rx_valid) begin
        unique case (rx_data)
          OP_PING: ok_req = 1'b1;
          OP_PAUSE: begin
            pause_set = 1'b1;
            dec_sig   = 1'b1;
          end
          OP_RESUME: begin
            arg_start = 1'b1;
            state_n   = ST_ARG;
          end
          OP_PROGRAM: begin
            arg_start = 1'b1;
            prog_sel  = 1'b1;
            state_n   = ST_ARG;
          end
          OP_NEXT: if (pause_reg) begin
            step_req = 1'b1;
            state_n  = ST_STEP_WAIT;
          end
          default: ;
        endcase
      end
      ST_ARG: begin
        if (rx_valid) begin
          arg_take = 1'b1;
          if (cnt == 2'd3) begin
            arg_last = 1'b1;
            state_n  = ST_CMD;
          end
        end else if (idle == TW'(ARG_TIMEOUT - 1)) begin
          state_n = ST_CMD;
        end
      end
      ST_STEP_WAIT: if (instr_done) begin
        dec_sig = 1'b1;
        state_n = ST_CMD;
      end
      default: state_n = ST_CMD;
    endcase
  end

  // Argument shift register, byte count and idle timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 2'd0;
      arg       <= 32'd0;
      idle      <= '0;
      exec_pend <= 1'b0;
      exec_prog <= 1'b0;
    end else begin
      exec_pend <= arg_last;
      if (arg_start) begin
        cnt       <= 2'd0;
        idle      <= '0;
        exec_prog <= prog_sel;
      end
      if (arg_take) begin
        arg  <= {rx_data, arg[31:8]};
        cnt  <= cnt + 2'd1;
        idle <= '0;
      end else if (state == ST_ARG) begin
        idle <= idle + 1'b1;
      end
    end
  end

  // CPU control: pause, breakpoint arming, step, program ptr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pause_reg <= 1'b0;
      armed     <= 1'b0;
      bp        <= '0;
      prog_ptr  <= '0;
      cpu_step  <= 1'b0;
    end else begin
      cpu_step <= step_req;
      if (instr_done) armed <= 1'b1;
      if (bp_hit) pause_reg <= 1'b1;
      if (exec_pend) begin
        if (exec_prog) begin
          prog_ptr <= prog_ptr + 1'b1;
        end else begin
          bp        <= PC_W'(arg);
          pause_reg <= 1'b0;
          armed     <= 1'b0;
          prog_ptr  <= '0;
        end
      end
      if (pause_set) pause_reg <= 1'b1;
    end
  end

  debug_tx_sched u_tx (
    .clk      (clk),
    .rst      (rst),
    .ok_req   (ok_req),
    .sig_req  (dec_sig | bp_hit),
    .sig_pc   (32'(cpu_pc)),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

endmodule

// File: tb/tb_debug_cmd_ctrl.sv
// Directed bench for debug_cmd_ctrl: command decode, frames,
// breakpoint, stepping, programming, timeout and reset.
module tb_debug_cmd_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] cpu_pc;
  logic        instr_done;
  logic        cpu_pause;
  logic        cpu_step;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;

  int vectors = 0;
  int miscompares = 0;
  int step_cnt = 0;
  int base;
  logic [7:0]  txq[$];
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  always #5 clk = ~clk;

  debug_cmd_ctrl #(.ARG_TIMEOUT(TMO), .PC_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .cpu_pc     (cpu_pc),
    .instr_done (instr_done),
    .cpu_pause  (cpu_pause),
    .cpu_step   (cpu_step),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata)
  );

  // Record accepted tx bytes, step pulses and program writes
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (cpu_step) step_cnt++;
      if (prog_we) begin
        wa.push_back(prog_addr);
        wd.push_back(prog_wdata);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  function automatic logic [31:0] txb(input int i);
    return (i < txq.size()) ? {24'd0, txq[i]} : 32'hDEAD_BEEF;
  endfunction

  task automatic chk_ok(input string tag, input int b);
    chk({tag, "_len"}, txq.size() - b, 1);
    chk({tag, "_b0"}, txb(b), 32'h02);
  endtask

  task automatic chk_frame(input string tag, input int b,
                           input logic [31:0] pc);
    logic [31:0] e;
    chk({tag, "_len"}, txq.size() - b, 5);
    chk({tag, "_hdr"}, txb(b), 32'h01);
    for (int k = 0; k < 4; k++) begin
      e = {24'd0, pc[8*k +: 8]};
      chk($sformatf("%s_pc%0d", tag, k), txb(b + 1 + k), e);
    end
  endtask

  task automatic wait_tx(input string tag);
    for (int i = 0; i < 20 && !tx_valid; i++) tick();
    chk(tag, tx_valid, 1);
  endtask

  initial begin
    rst = 1'b1;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    cpu_pc = 32'h0;
    instr_done = 1'b0;
    repeat (3) tick();
    chk("rst_pause", cpu_pause, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_step", cpu_step, 0);
    chk("rst_we", prog_we, 0);
    rst = 1'b0;
    tick();

    // PING
    base = txq.size();
    send(8'h03);
    repeat (6) tick();
    chk_ok("ping", base);
    chk("ping_pause", cpu_pause, 0);

    // PAUSE with pc 0x40
    base = txq.size();
    cpu_pc = 32'h40;
    send(8'h04);
    chk("pause_lvl", cpu_pause, 1);
    repeat (10) tick();
    chk_frame("pause", base, 32'h40);

    // RESUME with breakpoint 4
    cpu_pc = 32'h0;
    send(8'h05); send(8'h04); send(8'h00);
    send(8'h00); send(8'h00);
    repeat (2) tick();
    chk("res_run", cpu_pause, 0);
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    chk("res_pc0", cpu_pause, 0);
    base = txq.size();
    cpu_pc = 32'h4;
    #1;
    chk("bp_comb", cpu_pause, 1);
    repeat (11) tick();
    chk_frame("bp", base, 32'h4);
    chk("bp_held", cpu_pause, 1);

    // NEXT NEXT while paused
    send(8'h06);
    send(8'h06);
    repeat (3) tick();
    chk("step1", step_cnt, 1);
    base = txq.size();
    cpu_pc = 32'h8;
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    repeat (10) tick();
    chk_frame("step1", base, 32'h8);
    chk("step1_cnt", step_cnt, 1);
    send(8'h06);
    repeat (3) tick();
    chk("step2", step_cnt, 2);
    base = txq.size();
    cpu_pc = 32'hC;
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    repeat (10) tick();
    chk_frame("step2", base, 32'hC);

    // PROGRAM writes
    for (int r = 0; r < 2; r++) begin
      send(8'h07);
      for (int k = 0; k < 4; k++) send(8'h01);
    end
    for (int k = 0; k < 5; k++) send(8'h07);
    repeat (3) tick();
    chk("pw_n", wa.size(), 3);
    chk("pw_a0", (wa.size() > 0) ? wa[0] : 32'hDEAD_BEEF, 0);
    chk("pw_d0", (wd.size() > 0) ? wd[0] : 32'hDEAD_BEEF,
        32'h0101_0101);
    chk("pw_a1", (wa.size() > 1) ? wa[1] : 32'hDEAD_BEEF, 1);
    chk("pw_d1", (wd.size() > 1) ? wd[1] : 32'hDEAD_BEEF,
        32'h0101_0101);
    chk("pw_a2", (wa.size() > 2) ? wa[2] : 32'hDEAD_BEEF, 2);
    chk("pw_d2", (wd.size() > 2) ? wd[2] : 32'hDEAD_BEEF,
        32'h0707_0707);

    // Partial RESUME argument times out, then PING
    base = txq.size();
    send(8'h05);
    send(8'h12);
    repeat (TMO) tick();
    send(8'h03);
    repeat (6) tick();
    chk_ok("tmo", base);
    chk("tmo_pause", cpu_pause, 1);
    chk("tmo_pw", wa.size(), 3);

    // Back-pressure mid SIGNAL frame
    cpu_pc = 32'h1122_3344;
    base = txq.size();
    send(8'h04);
    wait_tx("bp_wait");
    tick();
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_v", tx_valid, 1);
      chk("hold_d", tx_data, 32'h33);
      tick();
    end
    tx_ready = 1'b1;
    repeat (10) tick();
    chk_frame("hold", base, 32'h1122_3344);

    // Reset mid-frame
    tx_ready = 1'b0;
    send(8'h03);
    wait_tx("rst_wait");
    rst = 1'b1;
    #1;
    chk("arst_txv", tx_valid, 0);
    chk("arst_pause", cpu_pause, 0);
    repeat (2) tick();
    rst = 1'b0;
    tx_ready = 1'b1;
    repeat (5) tick();
    chk("post_txv", tx_valid, 0);
    chk("post_pause", cpu_pause, 0);

    // Breakpoint hit together with PAUSE decode
    cpu_pc = 32'h30;
    send(8'h05); send(8'h20); send(8'h00);
    send(8'h00); send(8'h00);
    repeat (2) tick();
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    chk("sim_run", cpu_pause, 0);
    base = txq.size();
    cpu_pc = 32'h20;
    rx_data = 8'h04;
    rx_valid = 1'b1;
    #1;
    chk("sim_comb", cpu_pause, 1);
    tick();
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (14) tick();
    chk_frame("sim", base, 32'h20);
    chk("sim_pause", cpu_pause, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
